// File: rtl/sirv_tl_repeater_cnt.sv
// TileLink A-channel beat repeater: passes beats through, or captures one and replays it
// while io_repeat is held (level mode) or a fixed 1+R times (count mode).
module sirv_tl_repeater_cnt #(
    parameter int SRC_W  = 2,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_repeat,
    input  logic [CNT_W-1:0]    io_repeat_cnt,
    input  logic                io_flush,
    output logic                io_full,
    output logic [CNT_W-1:0]    io_remaining,
    output logic                io_enq_ready,
    input  logic                io_enq_valid,
    input  logic [2:0]          io_enq_bits_opcode,
    input  logic [2:0]          io_enq_bits_param,
    input  logic [2:0]          io_enq_bits_size,
    input  logic [SRC_W-1:0]    io_enq_bits_source,
    input  logic [ADDR_W-1:0]   io_enq_bits_address,
    input  logic [DATA_W/8-1:0] io_enq_bits_mask,
    input  logic [DATA_W-1:0]   io_enq_bits_data,
    input  logic                io_deq_ready,
    output logic                io_deq_valid,
    output logic [2:0]          io_deq_bits_opcode,
    output logic [2:0]          io_deq_bits_param,
    output logic [2:0]          io_deq_bits_size,
    output logic [SRC_W-1:0]    io_deq_bits_source,
    output logic [ADDR_W-1:0]   io_deq_bits_address,
    output logic [DATA_W/8-1:0] io_deq_bits_mask,
    output logic [DATA_W-1:0]   io_deq_bits_data
);

    // Handshakes: a beat transfers on a cycle where valid and ready are both high; valid
    // never depends on ready of the same channel, and a held beat stays stable until taken.
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                cmode_q, cmode_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [2:0]          saved_opcode_q, saved_opcode_d;
    logic [2:0]          saved_param_q, saved_param_d;
    logic [2:0]          saved_size_q, saved_size_d;
    logic [SRC_W-1:0]    saved_source_q, saved_source_d;
    logic [ADDR_W-1:0]   saved_address_q, saved_address_d;
    logic [DATA_W/8-1:0] saved_mask_q, saved_mask_d;
    logic [DATA_W-1:0]   saved_data_q, saved_data_d;

    logic enq_fire;
    logic deq_fire;

    always_comb begin
        state_d         = state_q;
        cmode_d         = cmode_q;
        remaining_d     = remaining_q;
        saved_opcode_d  = saved_opcode_q;
        saved_param_d   = saved_param_q;
        saved_size_d    = saved_size_q;
        saved_source_d  = saved_source_q;
        saved_address_d = saved_address_q;
        saved_mask_d    = saved_mask_q;
        saved_data_d    = saved_data_q;

        io_full             = (state_q == HOLD);
        io_remaining        = remaining_q;
        io_enq_ready        = io_deq_ready;
        io_deq_valid        = io_enq_valid;
        io_deq_bits_opcode  = io_enq_bits_opcode;
        io_deq_bits_param   = io_enq_bits_param;
        io_deq_bits_size    = io_enq_bits_size;
        io_deq_bits_source  = io_enq_bits_source;
        io_deq_bits_address = io_enq_bits_address;
        io_deq_bits_mask    = io_enq_bits_mask;
        io_deq_bits_data    = io_enq_bits_data;

        if (state_q == HOLD) begin
            io_enq_ready        = 1'b0;
            io_deq_valid        = 1'b1;
            io_deq_bits_opcode  = saved_opcode_q;
            io_deq_bits_param   = saved_param_q;
            io_deq_bits_size    = saved_size_q;
            io_deq_bits_source  = saved_source_q;
            io_deq_bits_address = saved_address_q;
            io_deq_bits_mask    = saved_mask_q;
            io_deq_bits_data    = saved_data_q;
        end

        enq_fire = io_enq_ready & io_enq_valid;
        deq_fire = io_deq_ready & io_deq_valid;

        case (state_q)
            IDLE: begin
                // The capturing beat's first emission is this same passthrough transfer.
                if (enq_fire && io_repeat) begin
                    state_d         = HOLD;
                    cmode_d         = (io_repeat_cnt != '0);
                    remaining_d     = io_repeat_cnt;
                    saved_opcode_d  = io_enq_bits_opcode;
                    saved_param_d   = io_enq_bits_param;
                    saved_size_d    = io_enq_bits_size;
                    saved_source_d  = io_enq_bits_source;
                    saved_address_d = io_enq_bits_address;
                    saved_mask_d    = io_enq_bits_mask;
                    saved_data_d    = io_enq_bits_data;
                end
            end
            HOLD: begin
                if (io_flush) begin
                    state_d     = IDLE;
                    cmode_d     = 1'b0;
                    remaining_d = '0;
                end else if (cmode_q) begin
                    // Guard on <=1 so the counter can never wrap below zero.
                    if (deq_fire) begin
                        if (remaining_q <= CNT_W'(1)) begin
                            state_d     = IDLE;
                            cmode_d     = 1'b0;
                            remaining_d = '0;
                        end else begin
                            remaining_d = remaining_q - CNT_W'(1);
                        end
                    end
                end else if (deq_fire && !io_repeat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            cmode_q         <= 1'b0;
            remaining_q     <= '0;
            saved_opcode_q  <= '0;
            saved_param_q   <= '0;
            saved_size_q    <= '0;
            saved_source_q  <= '0;
            saved_address_q <= '0;
            saved_mask_q    <= '0;
            saved_data_q    <= '0;
        end else begin
            state_q         <= state_d;
            cmode_q         <= cmode_d;
            remaining_q     <= remaining_d;
            saved_opcode_q  <= saved_opcode_d;
            saved_param_q   <= saved_param_d;
            saved_size_q    <= saved_size_d;
            saved_source_q  <= saved_source_d;
            saved_address_q <= saved_address_d;
            saved_mask_q    <= saved_mask_d;
            saved_data_q    <= saved_data_d;
        end
    end

endmodule

// File: tb/tb_sirv_tl_repeater_cnt.sv
// Directed bench for sirv_tl_repeater_cnt: passthrough, level and count replay,
// backpressure, flush, maximum count and mid-hold reset.
module tb_sirv_tl_repeater_cnt;

    localparam int SRC_W  = 2;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic                io_repeat;
    logic [CNT_W-1:0]    io_repeat_cnt;
    logic                io_flush;
    logic                io_full;
    logic [CNT_W-1:0]    io_remaining;
    logic                io_enq_ready;
    logic                io_enq_valid;
    logic [2:0]          io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size;
    logic [SRC_W-1:0]    io_enq_bits_source;
    logic [ADDR_W-1:0]   io_enq_bits_address;
    logic [DATA_W/8-1:0] io_enq_bits_mask;
    logic [DATA_W-1:0]   io_enq_bits_data;
    logic                io_deq_ready;
    logic                io_deq_valid;
    logic [2:0]          io_deq_bits_opcode, io_deq_bits_param, io_deq_bits_size;
    logic [SRC_W-1:0]    io_deq_bits_source;
    logic [ADDR_W-1:0]   io_deq_bits_address;
    logic [DATA_W/8-1:0] io_deq_bits_mask;
    logic [DATA_W-1:0]   io_deq_bits_data;

    int tests_run = 0;
    int tests_failed = 0;

    sirv_tl_repeater_cnt #(
        .SRC_W(SRC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io_repeat(io_repeat),
        .io_repeat_cnt(io_repeat_cnt),
        .io_flush(io_flush),
        .io_full(io_full),
        .io_remaining(io_remaining),
        .io_enq_ready(io_enq_ready),
        .io_enq_valid(io_enq_valid),
        .io_enq_bits_opcode(io_enq_bits_opcode),
        .io_enq_bits_param(io_enq_bits_param),
        .io_enq_bits_size(io_enq_bits_size),
        .io_enq_bits_source(io_enq_bits_source),
        .io_enq_bits_address(io_enq_bits_address),
        .io_enq_bits_mask(io_enq_bits_mask),
        .io_enq_bits_data(io_enq_bits_data),
        .io_deq_ready(io_deq_ready),
        .io_deq_valid(io_deq_valid),
        .io_deq_bits_opcode(io_deq_bits_opcode),
        .io_deq_bits_param(io_deq_bits_param),
        .io_deq_bits_size(io_deq_bits_size),
        .io_deq_bits_source(io_deq_bits_source),
        .io_deq_bits_address(io_deq_bits_address),
        .io_deq_bits_mask(io_deq_bits_mask),
        .io_deq_bits_data(io_deq_bits_data)
    );

    always #5 clock = ~clock;

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_enq(input logic v, input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data);
        io_enq_valid        = v;
        io_enq_bits_opcode  = op;
        io_enq_bits_param   = 3'd2;
        io_enq_bits_size    = 3'd2;
        io_enq_bits_source  = 2'd1;
        io_enq_bits_address = addr;
        io_enq_bits_mask    = 4'hF;
        io_enq_bits_data    = data;
    endtask

    logic rdy_seq [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [CNT_W-1:0] rem_seq [5] = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd1};

    initial begin
        reset = 1'b1;
        io_repeat = 1'b0;
        io_repeat_cnt = '0;
        io_flush = 1'b0;
        io_deq_ready = 1'b1;
        drive_enq(1'b0, 3'd0, '0, '0);
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk("reset_full", 64'(io_full), 64'd0);
        chk("reset_remaining", 64'(io_remaining), 64'd0);
        chk("reset_enq_ready", 64'(io_enq_ready), 64'd1);
        chk("reset_deq_valid", 64'(io_deq_valid), 64'd0);

        // 1: plain passthrough
        drive_enq(1'b1, 3'd4, 30'h100, 32'hDEAD_0001);
        settle();
        chk("pass_deq_valid", 64'(io_deq_valid), 64'd1);
        chk("pass_opcode", 64'(io_deq_bits_opcode), 64'd4);
        chk("pass_address", 64'(io_deq_bits_address), 64'h100);
        chk("pass_enq_ready", 64'(io_enq_ready), 64'd1);
        io_deq_ready = 1'b0;
        settle();
        chk("pass_enq_ready_bp", 64'(io_enq_ready), 64'd0);
        io_deq_ready = 1'b1;
        tick();
        chk("pass_full", 64'(io_full), 64'd0);

        // 2: level mode, 1 passthrough + 3 held beats
        io_repeat = 1'b1;
        io_repeat_cnt = '0;
        drive_enq(1'b1, 3'd1, 30'h200, 32'hA5A5_A5A5);
        settle();
        chk("lvl_beat1_data", 64'(io_deq_bits_data), 64'hA5A5_A5A5);
        tick();
        drive_enq(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) io_repeat = 1'b0;
            settle();
            chk("lvl_full", 64'(io_full), 64'd1);
            chk("lvl_deq_valid", 64'(io_deq_valid), 64'd1);
            chk("lvl_data", 64'(io_deq_bits_data), 64'hA5A5_A5A5);
            chk("lvl_addr", 64'(io_deq_bits_address), 64'h200);
            chk("lvl_enq_ready", 64'(io_enq_ready), 64'd0);
            chk("lvl_remaining", 64'(io_remaining), 64'd0);
            tick();
        end
        chk("lvl_end_full", 64'(io_full), 64'd0);
        chk("lvl_end_enq_ready", 64'(io_enq_ready), 64'd1);

        // 3: count mode R=3, io_repeat only on the capture cycle
        io_repeat = 1'b1;
        io_repeat_cnt = 4'd3;
        drive_enq(1'b1, 3'd0, 30'h300, 32'h1234_5678);
        settle();
        chk("cnt_beat1_data", 64'(io_deq_bits_data), 64'h1234_5678);
        chk("cnt_beat1_rem", 64'(io_remaining), 64'd0);
        tick();
        io_repeat = 1'b0;
        io_repeat_cnt = '0;
        drive_enq(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("cnt_full", 64'(io_full), 64'd1);
            chk("cnt_data", 64'(io_deq_bits_data), 64'h1234_5678);
            chk("cnt_remaining", 64'(io_remaining), 64'(3 - i));
            tick();
        end
        chk("cnt_end_full", 64'(io_full), 64'd0);
        chk("cnt_end_remaining", 64'(io_remaining), 64'd0);

        // 4: backpressure with R=2
        io_repeat = 1'b1;
        io_repeat_cnt = 4'd2;
        drive_enq(1'b1, 3'd0, 30'h400, 32'h0BAD_F00D);
        tick();
        io_repeat = 1'b0;
        drive_enq(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            io_deq_ready = rdy_seq[i];
            settle();
            chk("bp_full", 64'(io_full), 64'd1);
            chk("bp_remaining", 64'(io_remaining), 64'(rem_seq[i]));
            tick();
        end
        io_deq_ready = 1'b1;
        settle();
        chk("bp_end_full", 64'(io_full), 64'd0);
        chk("bp_end_remaining", 64'(io_remaining), 64'd0);

        // 5: flush in count mode R=5 with 4 remaining
        io_repeat = 1'b1;
        io_repeat_cnt = 4'd5;
        drive_enq(1'b1, 3'd0, 30'h500, 32'h5555_0000);
        tick();
        io_repeat = 1'b0;
        drive_enq(1'b0, 3'd0, '0, '0);
        tick();
        settle();
        chk("flush_pre_rem", 64'(io_remaining), 64'd4);
        io_flush = 1'b1;
        tick();
        io_flush = 1'b0;
        settle();
        chk("flush_full", 64'(io_full), 64'd0);
        chk("flush_remaining", 64'(io_remaining), 64'd0);
        drive_enq(1'b1, 3'd2, 30'h600, 32'hCAFE_BABE);
        settle();
        chk("flush_new_valid", 64'(io_deq_valid), 64'd1);
        chk("flush_new_data", 64'(io_deq_bits_data), 64'hCAFE_BABE);
        // flush in IDLE must not block a capture
        io_flush = 1'b1;
        io_repeat = 1'b1;
        io_repeat_cnt = 4'd1;
        tick();
        io_flush = 1'b0;
        io_repeat = 1'b0;
        drive_enq(1'b0, 3'd0, '0, '0);
        settle();
        chk("idle_flush_full", 64'(io_full), 64'd1);
        chk("idle_flush_data", 64'(io_deq_bits_data), 64'hCAFE_BABE);
        chk("idle_flush_rem", 64'(io_remaining), 64'd1);
        tick();
        chk("idle_flush_end", 64'(io_full), 64'd0);

        // maximum count R=15: exactly 15 held beats
        io_repeat = 1'b1;
        io_repeat_cnt = 4'd15;
        drive_enq(1'b1, 3'd0, 30'h700, 32'h7777_7777);
        tick();
        io_repeat = 1'b0;
        drive_enq(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < 15; i++) begin
            settle();
            chk("max_full", 64'(io_full), 64'd1);
            chk("max_remaining", 64'(io_remaining), 64'(15 - i));
            tick();
        end
        chk("max_end_full", 64'(io_full), 64'd0);
        chk("max_end_remaining", 64'(io_remaining), 64'd0);

        // 6: reset mid-HOLD with remaining=2
        io_repeat = 1'b1;
        io_repeat_cnt = 4'd3;
        drive_enq(1'b1, 3'd0, 30'h800, 32'h8888_1234);
        tick();
        io_repeat = 1'b0;
        drive_enq(1'b0, 3'd0, '0, '0);
        tick();
        settle();
        chk("rst_pre_rem", 64'(io_remaining), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("rst_full", 64'(io_full), 64'd0);
        chk("rst_remaining", 64'(io_remaining), 64'd0);
        chk("rst_saved_data", 64'(dut.saved_data_q), 64'd0);
        chk("rst_deq_valid", 64'(io_deq_valid), 64'd0);
        chk("rst_enq_ready", 64'(io_enq_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
